seg_scan_display: RTL and testbench

Eight-digit multiplexed seven-segment driver for the board-level CPU top. It takes a 32-bit word selected by the top (PC, ALU result, data-memory word, etc.) and shows it as eight hex digits on the shared SEG/AN pins. Values are double-buffered so the shown word only changes at a full-scan boundary, with no torn frames. It sits directly downstream of the CPU datapath and source-select logic, and drives the board pins.

---
 rtl/seg_scan_display_if.sv | 22 ++
 rtl/seg_scan_display.sv | 100 ++++++++++
 tb/tb_seg_scan_display.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_display_if.sv
// Display bus between the CPU top and the seven-segment scanner:
// word/strobe/controls in, board pin drive and status out.
interface seg_scan_display_if;
    logic [31:0] data;
    logic        load;
    logic [7:0]  dp_mask;
    logic        blank;
    logic [7:0]  SEG;
    logic [7:0]  AN;
    logic        pending;
    logic        frame;

    modport master (
        output data, load, dp_mask, blank,
        input  SEG, AN, pending, frame
    );

    modport slave (
        input  data, load, dp_mask, blank,
        output SEG, AN, pending, frame
    );
endinterface

// File: rtl/seg_scan_display.sv
// Eight-digit multiplexed hex display driver. The shown word is double-buffered
// and only swapped at a full-scan boundary so a frame is never torn.
module seg_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_display_if.slave  bus
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shown_q, shown_d;
    logic [31:0]      pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             frame_q, frame_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;

    logic       tick;
    logic       boundary;
    logic [3:0] nib;
    logic [6:0] code;
    logic [7:0] lz_blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Digit i is a leading zero when every nibble from i upward is zero.
    assign lz_blank[0] = 1'b0;
    for (genvar g = 1; g < 8; g++) begin : g_lz
        assign lz_blank[g] = BLANK_LZ && (shown_q[31:4*g] == '0);
    end

    assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign boundary = tick && (idx_q == 3'd7);
    assign nib      = 4'(shown_q >> {idx_q, 2'b00});
    assign code     = lz_blank[idx_q] ? 7'h7F : hex7(nib);

    always_comb begin
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        idx_d        = tick ? idx_q + 3'd1 : idx_q;
        shown_d      = shown_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        // A load landing on the boundary bypasses the pending slot entirely.
        if (bus.load && boundary) begin
            shown_d      = bus.data;
            pend_valid_d = 1'b0;
        end else if (bus.load) begin
            pend_d       = bus.data;
            pend_valid_d = 1'b1;
        end else if (boundary && pend_valid_q) begin
            shown_d      = pend_q;
            pend_valid_d = 1'b0;
        end
        frame_d = boundary;
        an_d    = bus.blank ? 8'hFF : ~(8'h01 << idx_q);
        seg_d   = bus.blank ? 8'hFF : {~bus.dp_mask[idx_q], code};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            shown_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            frame_q      <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 8'hFF;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            frame_q      <= frame_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bus.SEG     = seg_q;
    assign bus.AN      = an_q;
    assign bus.pending = pend_valid_q;
    assign bus.frame   = frame_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a cycle-count reference model queues
// the expected pin state per edge, a negedge monitor pops and compares.
module tb_seg_scan_display;
    localparam int SD = 4;
    localparam int FR = 8 * SD;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        logic       pend;
        logic       frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seg_scan_display_if bus();

    seg_scan_display #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: edges elapsed since reset, displayed word, waiting word.
    int          cnt     = 0;
    logic [31:0] m_shown = '0;
    logic [31:0] m_pend  = '0;
    bit          m_pv    = 1'b0;

    byte unsigned hex_tbl[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    function automatic logic [7:0] exp_seg(int d, logic [31:0] w, logic [7:0] dp, logic bl);
        logic [31:0] upper;
        byte unsigned t;
        logic [6:0] c;
        if (bl) return 8'hFF;
        upper = w >> (4 * d);
        t = hex_tbl[upper & 32'hF];
        c = (d != 0 && upper == 0) ? 7'h7F : t[6:0];
        return {~dp[d], c};
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, req);
        end
    endtask

    // Model: the state before each edge decides what the pins show after it.
    initial begin
        exp_t e;
        int   idx;
        bit   bnd;
        forever begin
            @(posedge clk);
            if (!rst) begin
                cnt = 0; m_shown = '0; m_pend = '0; m_pv = 1'b0;
                e = '{8'hFF, 8'hFF, 1'b0, 1'b0};
            end else begin
                idx = (cnt / SD) % 8;
                bnd = (cnt % FR) == FR - 1;
                e.an  = bus.blank ? 8'hFF : ~(8'h01 << idx);
                e.seg = exp_seg(idx, m_shown, bus.dp_mask, bus.blank);
                if (bus.load && bnd) begin
                    m_shown = bus.data; m_pv = 1'b0;
                end else if (bus.load) begin
                    m_pend = bus.data; m_pv = 1'b1;
                end else if (bnd && m_pv) begin
                    m_shown = m_pend; m_pv = 1'b0;
                end
                e.pend  = m_pv;
                e.frame = bnd;
                cnt++;
            end
            sb.push_back(e);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("AN",      bus.AN,             e.an);
                chk("SEG",     bus.SEG,            e.seg);
                chk("pending", {7'd0, bus.pending}, {7'd0, e.pend});
                chk("frame",   {7'd0, bus.frame},   {7'd0, e.frame});
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(logic [31:0] w);
        bus.data = w;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    // Park on the negedge whose following edge has frame position pos.
    task automatic wait_pos(int pos);
        int guard = 0;
        while ((cnt % FR) != pos && guard < 4 * FR) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 4 * FR) begin
            total++; bad++;
            $display("FAIL wait_pos: position %0d not reached, at %0d", pos, cnt % FR);
        end
    endtask

    initial begin
        bus.data = '0; bus.load = 1'b0; bus.dp_mask = '0; bus.blank = 1'b0;
        step(3);
        #1 rst = 1'b1;
        step(2 * FR + 6);

        // Double buffer
        wait_pos(9);
        do_load(32'h1234_ABCD);
        step(2 * FR);

        // Collision: bypass load on the boundary discards the waiting word
        wait_pos(10);
        do_load(32'h5555_5555);
        wait_pos(FR - 1);
        do_load(32'h0000_00F0);
        step(FR + 4);

        // Last load before the boundary wins
        wait_pos(3);
        do_load(32'h1);
        step(5);
        do_load(32'h2);
        step(2 * FR);

        // Decimal point and blanking
        bus.dp_mask = 8'h01;
        step(FR);
        bus.blank = 1'b1;
        step(11);
        bus.blank = 1'b0;
        step(FR);
        bus.dp_mask = 8'hA5;
        step(FR);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bus.load = ($urandom_range(0, 11) == 0);
            bus.data = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) bus.dp_mask = 8'($urandom);
            if ($urandom_range(0, 23) == 0) bus.blank = ~bus.blank;
            @(negedge clk);
        end
        bus.load = 1'b0; bus.blank = 1'b0; bus.dp_mask = '0;
        step(FR);

        // Reset mid-scan with a word pending at digit 5
        wait_pos(8);
        do_load(32'hDEAD_BEEF);
        wait_pos(5 * SD);
        #1 rst = 1'b0;
        #1;
        chk("rst_AN",      bus.AN,              8'hFF);
        chk("rst_SEG",     bus.SEG,             8'hFF);
        chk("rst_pending", {7'd0, bus.pending}, 8'h00);
        chk("rst_frame",   {7'd0, bus.frame},   8'h00);
        step(3);
        #1 rst = 1'b1;
        step(2 * FR);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
